// File: rtl/sseg_pkg.sv
// Shared 7-segment types, segment bit positions and the active-low hex font.
package sseg_pkg;

    typedef logic [7:0] sseg_n_t;

    localparam sseg_n_t SSEG_OFF_N = 8'hFF;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Returns {g,f,e,d,c,b,a}, active-low (0 lights the segment).
    function automatic logic [6:0] hex_font(input logic [3:0] hex);
        logic [6:0] seg_n;
        case (hex)
            4'h0: seg_n = 7'b1000000;
            4'h1: seg_n = 7'b1111001;
            4'h2: seg_n = 7'b0100100;
            4'h3: seg_n = 7'b0110000;
            4'h4: seg_n = 7'b0011001;
            4'h5: seg_n = 7'b0010010;
            4'h6: seg_n = 7'b0000010;
            4'h7: seg_n = 7'b1111000;
            4'h8: seg_n = 7'b0000000;
            4'h9: seg_n = 7'b0010000;
            4'hA: seg_n = 7'b0001000;
            4'hB: seg_n = 7'b0000011;
            4'hC: seg_n = 7'b1000110;
            4'hD: seg_n = 7'b0100001;
            4'hE: seg_n = 7'b0000110;
            default: seg_n = 7'b0001110;
        endcase
        return seg_n;
    endfunction

endpackage

// File: rtl/hex_to_sseg.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
module hex_to_sseg
    import sseg_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [6:0] o_seg_n
);

    always_comb begin
        o_seg_n = hex_font(i_hex);
    end

endmodule

// File: rtl/led_n_mux_pwm.sv
// N-digit 7-segment scanner with dead time, PWM brightness, leading-zero
// suppression, per-slot input shadowing and a frame tick.
module led_n_mux_pwm
    import sseg_pkg::*;
#(
    parameter int unsigned N_DIGITS         = 4,
    parameter int unsigned SLOT_CYC         = 50000,
    parameter int unsigned DEAD_CYC         = 1000,
    parameter int unsigned BRIGHT_W         = 3,
    parameter logic        LDSEL_ACTIVE_LOW = 1'b0
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [4*N_DIGITS-1:0]   i_hex,
    input  logic [N_DIGITS-1:0]     i_dp,
    input  logic [N_DIGITS-1:0]     i_blank,
    input  logic                    i_lz_suppress,
    input  logic [BRIGHT_W-1:0]     i_brightness,
    output logic [7:0]              o_sseg_n,
    output logic [N_DIGITS-1:0]     o_ldsel,
    output logic                    o_frame_tick
);

    localparam int unsigned CNT_W = $clog2(SLOT_CYC);
    localparam int unsigned IDX_W = $clog2(N_DIGITS);
    localparam int unsigned ON_W  = CNT_W + 1;
    localparam int unsigned STEP  = (SLOT_CYC - DEAD_CYC) >> BRIGHT_W;

    localparam logic [CNT_W-1:0]    SLOT_LAST      = CNT_W'(SLOT_CYC - 1);
    localparam logic [CNT_W-1:0]    DEAD_VAL       = CNT_W'(DEAD_CYC);
    localparam logic [IDX_W-1:0]    IDX_LAST       = IDX_W'(N_DIGITS - 1);
    localparam logic [N_DIGITS-1:0] LDSEL_INACTIVE = {N_DIGITS{LDSEL_ACTIVE_LOW}};

    logic [CNT_W-1:0]      slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
    logic [4*N_DIGITS-1:0] hex_sh_q, hex_sh_d;
    logic [N_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [N_DIGITS-1:0]   blank_sh_q, blank_sh_d;
    logic                  lz_sh_q, lz_sh_d;
    logic [BRIGHT_W-1:0]   bright_sh_q, bright_sh_d;
    sseg_n_t               sseg_q, sseg_d;
    logic [N_DIGITS-1:0]   ldsel_q, ldsel_d;
    logic                  tick_q, tick_d;

    logic                  slot_start;
    logic                  slot_end;
    logic [N_DIGITS-1:0]   lz_vec;
    logic                  all_zero;
    logic                  dark;
    logic [ON_W-1:0]       on_len;
    logic [CNT_W-1:0]      rel_cnt;
    logic                  lit;
    logic [3:0]            cur_hex;
    logic [6:0]            cur_font;

    always_comb begin
        slot_start  = (slot_cnt_q == '0);
        slot_end    = (slot_cnt_q == SLOT_LAST);
        slot_cnt_d  = slot_end ? '0 : slot_cnt_q + CNT_W'(1);
        digit_idx_d = digit_idx_q;
        if (slot_end) begin
            digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IDX_W'(1);
        end
    end

    // The _d shadow values double as the "effective" inputs for this slot, so the
    // capture cycle itself already uses the freshly sampled values.
    always_comb begin
        hex_sh_d    = hex_sh_q;
        dp_sh_d     = dp_sh_q;
        blank_sh_d  = blank_sh_q;
        lz_sh_d     = lz_sh_q;
        bright_sh_d = bright_sh_q;
        if (slot_start) begin
            hex_sh_d    = i_hex;
            dp_sh_d     = i_dp;
            blank_sh_d  = i_blank;
            lz_sh_d     = i_lz_suppress;
            bright_sh_d = i_brightness;
        end
    end

    // Walk down from the leftmost digit; digit 0 is never suppressed.
    always_comb begin
        lz_vec   = '0;
        all_zero = 1'b1;
        for (int k = int'(N_DIGITS) - 1; k >= 1; k--) begin
            all_zero  = all_zero && (hex_sh_d[4*k +: 4] == 4'h0);
            lz_vec[k] = lz_sh_d && all_zero;
        end
        dark    = blank_sh_d[digit_idx_q] | lz_vec[digit_idx_q];
        cur_hex = hex_sh_d[4*digit_idx_q +: 4];
    end

    always_comb begin
        on_len  = ON_W'((32'(bright_sh_d) + 32'd1) * STEP);
        rel_cnt = slot_cnt_q - DEAD_VAL;
        lit     = (slot_cnt_q >= DEAD_VAL) && ({1'b0, rel_cnt} < on_len) && !dark;
    end

    hex_to_sseg u_hex_to_sseg (
        .i_hex   (cur_hex),
        .o_seg_n (cur_font)
    );

    always_comb begin
        sseg_d  = SSEG_OFF_N;
        ldsel_d = LDSEL_INACTIVE;
        tick_d  = slot_end && (digit_idx_q == IDX_LAST);
        if (lit) begin
            sseg_d[SEG_G:SEG_A] = cur_font;
            sseg_d[SEG_DP]      = ~dp_sh_d[digit_idx_q];
            ldsel_d             = (N_DIGITS'(1) << digit_idx_q) ^ LDSEL_INACTIVE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            slot_cnt_q  <= '0;
            digit_idx_q <= '0;
            hex_sh_q    <= '0;
            dp_sh_q     <= '0;
            blank_sh_q  <= '0;
            lz_sh_q     <= 1'b0;
            bright_sh_q <= '0;
            sseg_q      <= SSEG_OFF_N;
            ldsel_q     <= LDSEL_INACTIVE;
            tick_q      <= 1'b0;
        end else begin
            slot_cnt_q  <= slot_cnt_d;
            digit_idx_q <= digit_idx_d;
            hex_sh_q    <= hex_sh_d;
            dp_sh_q     <= dp_sh_d;
            blank_sh_q  <= blank_sh_d;
            lz_sh_q     <= lz_sh_d;
            bright_sh_q <= bright_sh_d;
            sseg_q      <= sseg_d;
            ldsel_q     <= ldsel_d;
            tick_q      <= tick_d;
        end
    end

    assign o_sseg_n     = sseg_q;
    assign o_ldsel      = ldsel_q;
    assign o_frame_tick = tick_q;

endmodule
